// File: rtl/rpc_iobuf_seq.sv
// RPC DRAM I/O stage: registered DB/DQS datapath plus a turnaround FSM.
// The FSM inserts dead cycles and pull-down control between driver and
// receiver ownership of the data and strobe pads.
//
// state   | meaning
// IDLE    | bus released, pads weakly pulled, waiting for a request
// TX      | this side drives DB/DQS, write words accepted
// TURN    | dead cycles, nobody drives, datapath cleared
// RX      | device drives DB, sampled every cycle
module rpc_iobuf_seq #(
  parameter int DB_WIDTH = 16,
  parameter int TURN_CYC = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tx_req_i,
  input  logic                rx_req_i,
  input  logic                tx_valid_i,
  input  logic [DB_WIDTH-1:0] tx_data_i,
  output logic                tx_ready_o,
  output logic                rx_valid_o,
  output logic [DB_WIDTH-1:0] rx_data_o,
  output logic [CNT_W-1:0]    tx_cnt_o,
  output logic                busy_o,
  input  logic                clk_in_i,
  input  logic                clkn_in_i,
  input  logic                stb_in_i,
  input  logic                csn_in_i,
  output logic                clk_o,
  output logic                clkn_o,
  output logic                stb_o,
  output logic                csn_o,
  inout  wire                 dqs_io,
  inout  wire                 dqsn_io,
  inout  wire  [DB_WIDTH-1:0] db_io
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TX   = 2'd1;
  localparam logic [1:0] ST_TURN = 2'd2;
  localparam logic [1:0] ST_RX   = 2'd3;

  // Turn counter only needs to hold TURN_CYC-1.
  localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYC - 1);

  logic [1:0]          state_q, state_d;
  logic [TW-1:0]       turn_cnt_q, turn_cnt_d;
  logic [DB_WIDTH-1:0] dout_q, dout_d;
  logic                dqs_q, dqs_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DB_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic [3:0]          ctl_q, ctl_d;

  logic oe;
  logic ie;
  logic pd;

  // Pad enables decode straight from the registered state so they switch
  // in the first cycle of each new state.
  assign oe = (state_q == ST_TX);
  assign ie = (state_q == ST_RX);
  assign pd = (state_q == ST_IDLE) || (state_q == ST_TURN);

  // Next-state, datapath and counter updates.
  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    dout_d     = dout_q;
    dqs_d      = dqs_q;
    cnt_d      = cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    ctl_d      = {clk_in_i, clkn_in_i, stb_in_i, csn_in_i};
    case (state_q)
      ST_IDLE: begin
        if (tx_req_i) begin
          state_d = ST_TX;
        end else if (rx_req_i) begin
          state_d = ST_RX;
        end
      end
      ST_TX: begin
        if (tx_valid_i) begin
          dout_d = tx_data_i;
          dqs_d  = ~dqs_q;
          cnt_d  = cnt_q + 1'b1;
        end
        if (!tx_req_i) begin
          state_d    = ST_TURN;
          turn_cnt_d = TURN_LOAD;
        end
      end
      ST_TURN: begin
        // Clearing here guarantees the next TX starts driving zeros.
        dout_d = '0;
        dqs_d  = 1'b0;
        if (turn_cnt_q == '0) begin
          if (tx_req_i) begin
            state_d = ST_TX;
          end else if (rx_req_i) begin
            state_d = ST_RX;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          turn_cnt_d = turn_cnt_q - 1'b1;
        end
      end
      ST_RX: begin
        rx_data_d  = db_io;
        rx_valid_d = 1'b1;
        if (!rx_req_i || tx_req_i) begin
          state_d    = ST_TURN;
          turn_cnt_d = TURN_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset releases the bus immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      turn_cnt_q <= '0;
      dout_q     <= '0;
      dqs_q      <= 1'b0;
      cnt_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ctl_q      <= 4'b0101;
    end else begin
      state_q    <= state_d;
      turn_cnt_q <= turn_cnt_d;
      dout_q     <= dout_d;
      dqs_q      <= dqs_d;
      cnt_q      <= cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ctl_q      <= ctl_d;
    end
  end

  assign tx_ready_o = oe;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  assign tx_cnt_o   = cnt_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign clk_o      = ctl_q[3];
  assign clkn_o     = ctl_q[2];
  assign stb_o      = ctl_q[1];
  assign csn_o      = ctl_q[0];

  // Behavioural pads: strong drivers in TX, weak pulls while released.
  assign db_io   = oe ? dout_q : {DB_WIDTH{1'bz}};
  assign dqs_io  = oe ? dqs_q  : 1'bz;
  assign dqsn_io = oe ? ~dqs_q : 1'bz;

  assign (pull0, pull1) db_io   = pd ? {DB_WIDTH{1'b0}} : {DB_WIDTH{1'bz}};
  assign (pull0, pull1) dqs_io  = pd ? 1'b0 : 1'bz;
  assign (pull0, pull1) dqsn_io = pd ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_rpc_iobuf_seq.sv
// Directed bench for rpc_iobuf_seq: vector table on the default 16-bit
// instance plus hand sequences for control pins, an 8-bit/TURN_CYC=1/CNT_W=4
// instance and asynchronous reset in the middle of a TX burst.
module tb_rpc_iobuf_seq;

  logic clk;
  logic rst;

  // 16-bit instance signals
  logic        tx_req, rx_req, tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready, rx_valid, busy;
  logic [15:0] rx_data;
  logic [15:0] tx_cnt;
  logic        clk_in, clkn_in, stb_in, csn_in;
  logic        clk_out, clkn_out, stb_out, csn_out;
  wire         dqs16, dqsn16;
  wire  [15:0] db16;
  logic        dev_oe;
  logic [15:0] dev_data;

  // 8-bit instance signals
  logic        tx_req8, rx_req8, tx_valid8;
  logic [7:0]  tx_data8;
  logic        tx_ready8, rx_valid8, busy8;
  logic [7:0]  rx_data8;
  logic [3:0]  tx_cnt8;
  logic        clk_o8, clkn_o8, stb_o8, csn_o8;
  wire         dqs8, dqsn8;
  wire  [7:0]  db8;
  logic        dev_oe8;
  logic [7:0]  dev_data8;

  int checks;
  int failures;

  assign db16 = dev_oe  ? dev_data  : 16'hzzzz;
  assign db8  = dev_oe8 ? dev_data8 : 8'hzz;

  rpc_iobuf_seq u_dut (
    .clk_i(clk), .rst_i(rst),
    .tx_req_i(tx_req), .rx_req_i(rx_req), .tx_valid_i(tx_valid), .tx_data_i(tx_data),
    .tx_ready_o(tx_ready), .rx_valid_o(rx_valid), .rx_data_o(rx_data),
    .tx_cnt_o(tx_cnt), .busy_o(busy),
    .clk_in_i(clk_in), .clkn_in_i(clkn_in), .stb_in_i(stb_in), .csn_in_i(csn_in),
    .clk_o(clk_out), .clkn_o(clkn_out), .stb_o(stb_out), .csn_o(csn_out),
    .dqs_io(dqs16), .dqsn_io(dqsn16), .db_io(db16)
  );

  rpc_iobuf_seq #(.DB_WIDTH(8), .TURN_CYC(1), .CNT_W(4)) u_dut8 (
    .clk_i(clk), .rst_i(rst),
    .tx_req_i(tx_req8), .rx_req_i(rx_req8), .tx_valid_i(tx_valid8), .tx_data_i(tx_data8),
    .tx_ready_o(tx_ready8), .rx_valid_o(rx_valid8), .rx_data_o(rx_data8),
    .tx_cnt_o(tx_cnt8), .busy_o(busy8),
    .clk_in_i(clk_in), .clkn_in_i(clkn_in), .stb_in_i(stb_in), .csn_in_i(csn_in),
    .clk_o(clk_o8), .clkn_o(clkn_o8), .stb_o(stb_o8), .csn_o(csn_o8),
    .dqs_io(dqs8), .dqsn_io(dqsn8), .db_io(db8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        txr, rxr, v;
    logic [15:0] data;
    logic        doe;
    logic [15:0] ddata;
    logic        busy, oe, ie, pd, rdy;
    logic [15:0] db;
    logic        dqs, rxv;
    logic [15:0] rxd, cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic txr, logic rxr, logic v, logic [15:0] data,
                              logic doe, logic [15:0] ddata,
                              logic b, logic oe, logic ie, logic pd, logic rdy,
                              logic [15:0] db, logic dqs, logic rxv,
                              logic [15:0] rxd, logic [15:0] cnt);
    vec_t r;
    r.txr = txr; r.rxr = rxr; r.v = v; r.data = data; r.doe = doe; r.ddata = ddata;
    r.busy = b; r.oe = oe; r.ie = ie; r.pd = pd; r.rdy = rdy;
    r.db = db; r.dqs = dqs; r.rxv = rxv; r.rxd = rxd; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    tx_req = 0; rx_req = 0; tx_valid = 0; tx_data = '0;
    dev_oe = 0; dev_data = '0;
    tx_req8 = 0; rx_req8 = 0; tx_valid8 = 0; tx_data8 = '0;
    dev_oe8 = 0; dev_data8 = '0;
    // Inputs opposite to reset values: outputs must stay at reset values.
    clk_in = 1; clkn_in = 0; stb_in = 1; csn_in = 0;
    #1;
    chk("reset_cnt_pre_edge", 32'(tx_cnt), 32'h0);
    chk("reset_ctl_pre_edge", {28'h0, clk_out, clkn_out, stb_out, csn_out}, 32'h5);
    step();
    step();
    chk("reset_ctl_held", {28'h0, clk_out, clkn_out, stb_out, csn_out}, 32'h5);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_rx", {15'h0, rx_valid, rx_data}, 32'h0);
    chk("reset_ready", 32'(tx_ready), 32'h0);
    chk("reset_pd", {29'h0, u_dut.oe, u_dut.ie, u_dut.pd}, 32'h1);
    clk_in = 0; clkn_in = 1; stb_in = 0; csn_in = 1;
    rst = 1'b0;

    //             txr rxr v  data     doe ddata     busy oe ie pd rdy db       dqs rxv rxd      cnt
    vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'd0));
    vecs.push_back(mk(1, 0, 1, 16'h0001, 0, 16'h0000, 1, 1, 0, 0, 1, 16'h0001, 1, 0, 16'h0000, 16'd1));
    vecs.push_back(mk(1, 0, 1, 16'h0002, 0, 16'h0000, 1, 1, 0, 0, 1, 16'h0002, 0, 0, 16'h0000, 16'd2));
    vecs.push_back(mk(1, 0, 1, 16'h0003, 0, 16'h0000, 1, 1, 0, 0, 1, 16'h0003, 1, 0, 16'h0000, 16'd3));
    vecs.push_back(mk(1, 0, 0, 16'hFFFF, 0, 16'h0000, 1, 1, 0, 0, 1, 16'h0003, 1, 0, 16'h0000, 16'd3));
    vecs.push_back(mk(1, 1, 0, 16'hFFFF, 0, 16'h0000, 1, 1, 0, 0, 1, 16'h0003, 1, 0, 16'h0000, 16'd3));
    vecs.push_back(mk(1, 0, 1, 16'h0004, 0, 16'h0000, 1, 1, 0, 0, 1, 16'h0004, 0, 0, 16'h0000, 16'd4));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'd4));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'd4));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'd4));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 16'hBEEF, 1, 0, 1, 0, 0, 16'h0000, 0, 1, 16'hBEEF, 16'd4));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h1234, 1, 0, 1, 0, 0, 16'h0000, 0, 1, 16'h1234, 16'd4));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 16'h5678, 1, 0, 0, 1, 0, 16'h0000, 0, 1, 16'h5678, 16'd4));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0000, 0, 0, 16'h5678, 16'd4));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 1, 16'h0000, 0, 0, 16'h5678, 16'd4));
    vecs.push_back(mk(1, 0, 1, 16'hFFFF, 0, 16'h0000, 1, 1, 0, 0, 1, 16'hFFFF, 1, 0, 16'h5678, 16'd5));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0000, 0, 0, 16'h5678, 16'd5));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 0, 16'h0000, 0, 0, 16'h5678, 16'd5));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 16'h5678, 16'd5));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 16'hCAFE, 1, 0, 1, 0, 0, 16'h0000, 0, 0, 16'h5678, 16'd5));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 16'hCAFE, 1, 0, 0, 1, 0, 16'h0000, 0, 1, 16'hCAFE, 16'd5));

    for (int i = 0; i < vecs.size(); i++) begin
      tx_req = vecs[i].txr; rx_req = vecs[i].rxr; tx_valid = vecs[i].v;
      tx_data = vecs[i].data; dev_oe = vecs[i].doe; dev_data = vecs[i].ddata;
      step();
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("v%0d_oe_ie_pd", i), {29'h0, u_dut.oe, u_dut.ie, u_dut.pd},
          {29'h0, vecs[i].oe, vecs[i].ie, vecs[i].pd});
      chk($sformatf("v%0d_ready", i), 32'(tx_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d_cnt", i), 32'(tx_cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_rx", i), {15'h0, rx_valid, rx_data}, {15'h0, vecs[i].rxv, vecs[i].rxd});
      if (vecs[i].oe) begin
        chk($sformatf("v%0d_db", i), 32'(db16), 32'(vecs[i].db));
        chk($sformatf("v%0d_dqs", i), {30'h0, dqs16, dqsn16}, {30'h0, vecs[i].dqs, ~vecs[i].dqs});
      end
    end

    // Control pins: exactly one cycle of latency.
    clk_in = 1; clkn_in = 0; stb_in = 1; csn_in = 0;
    #1;
    chk("ctl_before_edge", {28'h0, clk_out, clkn_out, stb_out, csn_out}, 32'h5);
    step();
    chk("ctl_after_edge", {28'h0, clk_out, clkn_out, stb_out, csn_out}, 32'hA);
    clk_in = 0; clkn_in = 1; stb_in = 1; csn_in = 1;
    step();
    chk("ctl_second", {28'h0, clk_out, clkn_out, stb_out, csn_out}, 32'h7);

    // 8-bit instance: counter wrap, single dead cycle, 8-bit capture.
    tx_req8 = 1;
    step();
    chk("w8_tx_entered", {30'h0, u_dut8.oe, tx_ready8}, 32'h3);
    for (int i = 0; i < 17; i++) begin
      tx_valid8 = 1; tx_data8 = 8'(i + 8'h20);
      step();
      if (i == 15) chk("w8_cnt_wrap0", 32'(tx_cnt8), 32'h0);
    end
    tx_valid8 = 0;
    chk("w8_cnt_17", 32'(tx_cnt8), 32'h1);
    chk("w8_db_last", 32'(db8), 32'h30);
    tx_req8 = 0; rx_req8 = 1;
    step();
    chk("w8_turn", {29'h0, u_dut8.oe, u_dut8.ie, u_dut8.pd}, 32'h1);
    dev_oe8 = 1; dev_data8 = 8'h5A;
    step();
    chk("w8_rx_after_1_dead", {29'h0, u_dut8.oe, u_dut8.ie, u_dut8.pd}, 32'h2);
    step();
    chk("w8_rx_data", {23'h0, rx_valid8, rx_data8}, {23'h0, 1'b1, 8'h5A});
    rx_req8 = 0;
    step();
    dev_oe8 = 0;

    // 16-bit instance back into TX, then asynchronous reset mid-burst.
    dev_oe = 0; tx_req = 1; rx_req = 0; tx_valid = 0;
    begin : wait_tx
      int n;
      n = 0;
      while (!u_dut.oe && n < 10) begin
        step();
        n++;
      end
      chk("wait_tx_entry_in_budget", 32'(u_dut.oe), 32'h1);
    end
    tx_valid = 1; tx_data = 16'hA5A5;
    step();
    tx_valid = 0;
    chk("mid_db_a5a5", 32'(db16), 32'hA5A5);
    clk_in = 1; clkn_in = 0; stb_in = 0; csn_in = 0;
    step();
    chk("mid_ctl_driven", {28'h0, clk_out, clkn_out, stb_out, csn_out}, 32'h8);
    chk("mid_cnt_nonzero", 32'(tx_cnt), 32'd6);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_pads_released", {29'h0, u_dut.oe, u_dut.ie, u_dut.pd}, 32'h1);
    chk("arst_cnt", 32'(tx_cnt), 32'h0);
    chk("arst_ctl", {28'h0, clk_out, clkn_out, stb_out, csn_out}, 32'h5);
    chk("arst_busy_ready", {30'h0, busy, tx_ready}, 32'h0);
    step();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
